// File: rtl/clock_request_ctrl.sv
// Clock request controller: aggregates per-requester clock demand into a single
// request toward a clock_module_sync node, grants requesters only while the gated
// clock is running, and holds the parent request for HOLD_CYCLES idle cycles
// before letting the clock stop.
//
// Optional feature: define CLOCK_REQUEST_CTRL_WAKE_COUNT_EN to add a saturating
// 16-bit wake_count output that counts OFF->STARTING transitions.
module clock_request_ctrl #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic               clock,
  input  logic               async_resetn,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic               parent_request,
  input  logic               parent_ready,
  input  logic               parent_silent,
  input  logic               parent_starting,
  input  logic               parent_stopping,
  output logic [2:0]         state
`ifdef CLOCK_REQUEST_CTRL_WAKE_COUNT_EN
  ,
  output logic [15:0]        wake_count
`endif
);

  typedef enum logic [2:0] {
    StOff      = 3'd0,
    StStarting = 3'd1,
    StOn       = 3'd2,
    StHold     = 3'd3,
    StStopping = 3'd4
  } state_e;

  // Counter value loaded on HOLD entry; unused when HOLD_CYCLES is 0 (HOLD is skipped).
  localparam logic [7:0] HoldLoad = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;

  state_e     state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       any_req;

  // Node transition status is informational only and never steers the FSM.
  logic       status_unused;
  assign status_unused = parent_starting ^ parent_stopping;

  assign any_req = |req;

  // Next-state and hold counter control.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      StOff: begin
        if (any_req) state_d = StStarting;
      end
      StStarting: begin
        if (parent_ready) state_d = StOn;
      end
      StOn: begin
        if (!parent_ready) begin
          // Clock lost under us: keep requesting and wait for ready again.
          state_d = StStarting;
        end else if (!any_req) begin
          if (HOLD_CYCLES == 0) begin
            state_d = StStopping;
          end else begin
            state_d    = StHold;
            hold_cnt_d = HoldLoad;
          end
        end
      end
      StHold: begin
        if (!parent_ready) begin
          state_d = StStarting;
        end else if (any_req) begin
          state_d    = StOn;
          hold_cnt_d = HoldLoad;
        end else if (hold_cnt_q == 8'd0) begin
          state_d = StStopping;
        end else begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end
      end
      StStopping: begin
        // A stop in flight always completes; pending demand restarts straight away.
        if (parent_silent) state_d = any_req ? StStarting : StOff;
      end
      default: begin
        state_d = StOff;
      end
    endcase
  end

  // State and hold counter registers.
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      state_q    <= StOff;
      hold_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Outputs decoded from registered state; ack is qualified by the ON state.
  always_comb begin
    parent_request = 1'b0;
    case (state_q)
      StStarting, StOn, StHold: parent_request = 1'b1;
      default:                  parent_request = 1'b0;
    endcase
    ack   = (state_q == StOn) ? req : '0;
    state = state_q;
  end

`ifdef CLOCK_REQUEST_CTRL_WAKE_COUNT_EN
  logic [15:0] wake_cnt_q;

  // Count wakes from OFF, saturating at all-ones.
  always_ff @(posedge clock or negedge async_resetn) begin
    if (!async_resetn) begin
      wake_cnt_q <= 16'd0;
    end else if (state_q == StOff && state_d == StStarting && wake_cnt_q != 16'hFFFF) begin
      wake_cnt_q <= wake_cnt_q + 16'd1;
    end
  end

  assign wake_count = wake_cnt_q;
`endif

endmodule

// File: tb/tb_clock_request_ctrl.sv
// Randomized self-checking bench for clock_request_ctrl. Three instances with
// HOLD_CYCLES of 8, 1 and 0 share one stimulus stream and are each compared
// against a behavioural model of the request/hold/stop rules.
module tb_clock_request_ctrl;

  localparam int NumDut = 3;
  localparam int NumCyc = 4000;

  logic       clock = 1'b0;
  logic       async_resetn;
  logic [3:0] req;
  logic       parent_ready, parent_silent, parent_starting, parent_stopping;

  logic [3:0] ack  [NumDut];
  logic       preq [NumDut];
  logic [2:0] st   [NumDut];
`ifdef CLOCK_REQUEST_CTRL_WAKE_COUNT_EN
  logic [15:0] wc  [NumDut];
`endif

  always #5 clock = ~clock;

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    localparam int unsigned Hold = (g == 0) ? 8 : (g == 1) ? 1 : 0;
    clock_request_ctrl #(
      .NUM_REQ    (4),
      .HOLD_CYCLES(Hold)
    ) u_dut (
      .clock          (clock),
      .async_resetn   (async_resetn),
      .req            (req),
      .ack            (ack[g]),
      .parent_request (preq[g]),
      .parent_ready   (parent_ready),
      .parent_silent  (parent_silent),
      .parent_starting(parent_starting),
      .parent_stopping(parent_stopping),
      .state          (st[g])
`ifdef CLOCK_REQUEST_CTRL_WAKE_COUNT_EN
      ,
      .wake_count     (wc[g])
`endif
    );
  end

  // Behavioural model: phase code plus count of idle HOLD cycles seen so far.
  localparam int MOff = 0, MStarting = 1, MOn = 2, MHold = 3, MStopping = 4;

  typedef struct {
    int st;
    int idle;
    int wakes;
  } model_t;

  model_t mdl [NumDut];
  int     n_checks = 0;
  int     n_errors = 0;

  function automatic int hold_of(input int g);
    return (g == 0) ? 8 : (g == 1) ? 1 : 0;
  endfunction

  function automatic model_t model_step(input model_t m, input int hold, input logic [3:0] r,
                                        input logic rdy, input logic sil);
    model_t n;
    bit     busy;
    n    = m;
    busy = (r != 4'd0);
    case (m.st)
      MOff: if (busy) begin
        n.st = MStarting;
        if (n.wakes < 65535) n.wakes = n.wakes + 1;
      end
      MStarting: if (rdy) n.st = MOn;
      MOn: begin
        if (!rdy) n.st = MStarting;
        else if (!busy) begin
          n.idle = 0;
          n.st   = (hold == 0) ? MStopping : MHold;
        end
      end
      MHold: begin
        if (!rdy) n.st = MStarting;
        else if (busy) n.st = MOn;
        else begin
          n.idle = n.idle + 1;
          if (n.idle == hold) n.st = MStopping;
        end
      end
      MStopping: if (sil) n.st = busy ? MStarting : MOff;
      default: n.st = MOff;
    endcase
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int g = 0; g < NumDut; g++) begin
      bit exp_preq;
      exp_preq = (mdl[g].st == MStarting || mdl[g].st == MOn || mdl[g].st == MHold);
      check_eq($sformatf("%s state[%0d]", tag, g), 32'(st[g]), 32'(mdl[g].st));
      check_eq($sformatf("%s parent_request[%0d]", tag, g), 32'(preq[g]), 32'(exp_preq));
`ifdef CLOCK_REQUEST_CTRL_WAKE_COUNT_EN
      check_eq($sformatf("%s wake_count[%0d]", tag, g), 32'(wc[g]), 32'(mdl[g].wakes));
`endif
    end
  endtask

  task automatic check_ack(input string tag);
    for (int g = 0; g < NumDut; g++) begin
      logic [3:0] exp_ack;
      exp_ack = (mdl[g].st == MOn) ? req : 4'd0;
      check_eq($sformatf("%s ack[%0d]", tag, g), 32'(ack[g]), 32'(exp_ack));
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < NumDut; g++) mdl[g] = '{st: MOff, idle: 0, wakes: 0};
  endtask

  task automatic model_advance();
    for (int g = 0; g < NumDut; g++)
      mdl[g] = model_step(mdl[g], hold_of(g), req, parent_ready, parent_silent);
  endtask

  initial begin
    int req_density;
    int ready_pct;

    async_resetn    = 1'b0;
    req             = 4'b1111;
    parent_ready    = 1'b1;
    parent_silent   = 1'b1;
    parent_starting = 1'b0;
    parent_stopping = 1'b0;
    req_density     = 2;
    ready_pct       = 97;
    model_reset();

    #2;
    check_regs("por");
    check_ack("por");
    @(negedge clock);
    check_regs("por_edge");
    req           = 4'd0;
    parent_silent = 1'b0;
    async_resetn  = 1'b1;
    #1;
    model_advance();

    for (int cyc = 0; cyc < NumCyc; cyc++) begin
      if (cyc % 96 == 0) begin
        req_density = int'($urandom_range(0, 3));
        ready_pct   = ($urandom_range(0, 3) == 0) ? 60 : 97;
      end
      @(negedge clock);
      check_regs("run");

      req             = ($urandom_range(0, 3) < req_density) ? 4'($urandom_range(1, 15)) : 4'd0;
      parent_ready    = (int'($urandom_range(0, 99)) < ready_pct);
      parent_silent   = ($urandom_range(0, 3) == 0);
      parent_starting = 1'($urandom);
      parent_stopping = 1'($urandom);
      #1;
      check_ack("run");

      if (cyc % 613 == 400) begin
        // Asynchronous reset between edges must clear everything immediately.
        async_resetn = 1'b0;
        #1;
        model_reset();
        check_regs("arst");
        check_ack("arst");
        @(negedge clock);
        check_regs("arst_held");
        async_resetn = 1'b1;
        #1;
        check_ack("arst_rel");
      end
      model_advance();
    end

    @(negedge clock);
    check_regs("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_request_ctrl.md
CLOCK_REQUEST_CTRL -- requirements
Module: clock_request_ctrl

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (1..16).
REQ-002 SHALL have parameter HOLD_CYCLES, default 8, idle cycles the parent request is held after the last requester drops (0..255).
REQ-003 SHALL have port clock  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port async_resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester clock demand, level.
REQ-006 SHALL have port ack  output  NUM_REQ  per-requester grant, meaning the gated clock is running.
REQ-007 SHALL have port parent_request  output  1  demand toward the clock_module_sync node.
REQ-008 SHALL have port parent_ready  input  1  node reports the gated clock is running.
REQ-009 SHALL have port parent_silent  input  1  node reports the gated clock is stopped.
REQ-010 SHALL have port parent_starting  input  1  node is in start transition; status only.
REQ-011 SHALL have port parent_stopping  input  1  node is in stop transition; status only.
REQ-012 SHALL have port state  output  3  current FSM state encoding.

Function
REQ-013 SHALL implement FSM states OFF=0, STARTING=1, ON=2, HOLD=3, STOPPING=4, with codes 5-7 recovering to OFF on the next edge.
REQ-014 SHALL take the OFF->STARTING transition on the first edge where any req bit=1.
REQ-015 SHALL take the STARTING->ON transition on the first edge where parent_ready=1.
REQ-016 SHALL take the ON->HOLD transition when req==0 and HOLD_CYCLES>0, and the ON->STOPPING transition when req==0 and HOLD_CYCLES==0.
REQ-017 SHALL, in HOLD, return to ON on any req bit=1 and reload the counter, or enter STOPPING after exactly HOLD_CYCLES consecutive HOLD cycles with req==0.
REQ-018 SHALL take the STOPPING->OFF transition on the first edge where parent_silent=1; requests arriving in STOPPING SHALL NOT abort the stop.
REQ-019 SHALL, when leaving STOPPING with req!=0 on that edge, go directly to STARTING.
REQ-020 SHALL decode parent_request from the state register only (no combinational path from req): 1 in STARTING, ON and HOLD; 0 in OFF and STOPPING.
REQ-021 SHALL drive ack[i] = req[i] AND (state==ON), with no ack in HOLD, STARTING or STOPPING.
REQ-022 SHALL, on parent_ready falling while in ON or HOLD, go to STARTING with parent_request kept at 1 and ack deasserted until ready returns.
REQ-023 SHALL implement the hold counter as 8 bits: load HOLD_CYCLES-1 on HOLD entry, decrement each HOLD cycle, exit at 0, never wrap.
REQ-024 SHALL ignore parent_starting and parent_stopping in transitions.

Reset
REQ-025 SHALL, with async_resetn=0, immediately force state=OFF, parent_request=0, ack=0 and hold counter=0.
REQ-026 SHALL apply reset mid-operation (any state) the same way, with no handshake completion.
REQ-027 SHALL make reset deassertion take effect on the next clock edge; req sampled normally from then on.

Configuration
REQ-028 SHALL, with macro CLOCK_REQUEST_CTRL_WAKE_COUNT_EN defined, add output wake_count (16 bits) that increments on each OFF->STARTING transition, saturates at 0xFFFF, and resets to 0.
REQ-029 SHALL, without CLOCK_REQUEST_CTRL_WAKE_COUNT_EN, have no wake_count port and no counter logic, with all other behaviour identical.

Verification
REQ-030 SHALL cover basic wake: req=4'b0001 at t0, parent_ready=1 two cycles later -> parent_request=1 one edge after t0, ack=4'b0001 the edge after ready, state=2.
REQ-031 SHALL cover hold then stop: HOLD_CYCLES=8, req drops to 0 -> state=3 for exactly 8 cycles, then state=4, parent_request=0; parent_silent=1 -> state=0.
REQ-032 SHALL cover rescue in hold: req=0 for 5 cycles, then req=4'b0100 -> state returns to 2, ack=4'b0100, parent_request never drops.
REQ-033 SHALL cover request during stop: req=4'b1000 in STOPPING -> parent_request stays 0 until parent_silent=1, then state=1 and parent_request=1 on the same edge.
REQ-034 SHALL cover ready loss and reset: parent_ready drops in ON -> state=1, ack=0; async_resetn=0 mid-STARTING -> state=0, parent_request=0 with no clock edge.
REQ-035 SHALL cover the wake counter with CLOCK_REQUEST_CTRL_WAKE_COUNT_EN: 3 full wake/stop cycles -> wake_count=3; a HOLD->ON rescue does not increment it.
